// File: rtl/sketch_ram_init_pkg.sv
// Shared definitions for the bucket-RAM initialiser.
// Holds the pass mode encodings, the per-channel FSM state encoding,
// the LFSR feedback constants, the default geometry/timeout values,
// and the LFSR step helper.
package sketch_pkg;

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_PRNG  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_GAP    = 3'd2,
        ST_FIN    = 3'd3,
        ST_ERR    = 3'd4
    } ch_state_e;

    // Galois toggle mask for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam int DEF_BASE_DEPTH = 2140;
    localparam int DEF_TIMEOUT    = 255;

    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = cur >> 4'd1;
        if (cur[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sketch_ram_init_if.sv
// Port bundle between the initialiser and its NUM_CH bucket RAMs.
// Channel k occupies bit k of enb/web/dob_valid and slice k of addrb/dib/dob.
//   master : initialiser side (drives enb, web, addrb, dib)
//   slave  : RAM side (drives dob, dob_valid)
interface sketch_ram_init_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 4,
    parameter int ADDR_W = 12
);
    logic [NUM_CH-1:0]        enb;
    logic [NUM_CH-1:0]        web;
    logic [NUM_CH*ADDR_W-1:0] addrb;
    logic [NUM_CH*DATA_W-1:0] dib;
    logic [NUM_CH*DATA_W-1:0] dob;
    logic [NUM_CH-1:0]        dob_valid;

    modport master (output enb, web, addrb, dib, input dob, dob_valid);
    modport slave  (input enb, web, addrb, dib, output dob, dob_valid);
endinterface

// File: rtl/sketch_ram_init_ch.sv
// One channel of the initialiser: walks addresses 0..DEPTH-1, one access per
// ACCESS state followed by a single idle GAP cycle, with a per-access wait
// timeout and a 16-bit Galois LFSR for pseudo-random fill.
// Ports:
//   sys_clk, rst_n          clock / async active-low reset
//   start                   accepted start from the top (mode/fill_value valid)
//   abort                   some channel is in ERR; drop to FIN
//   fin_ack                 top's done pulse; leave FIN for IDLE
//   dob, dob_valid          RAM read data / access complete
//   enb, web, addrb, dib    registered RAM port outputs
//   in_fin, in_err          state flags for the top
//   timeout_hit, mism       one-cycle event strobes for error / mismatch count
module sketch_ram_init_ch
    import sketch_pkg::*;
#(
    parameter int          DATA_W  = 4,
    parameter int          ADDR_W  = 12,
    parameter int          DEPTH   = DEF_BASE_DEPTH,
    parameter int          TIMEOUT = DEF_TIMEOUT,
    parameter logic [15:0] SEED    = LFSR_SEED
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              fin_ack,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [DATA_W-1:0] dob,
    input  logic              dob_valid,
    output logic              enb,
    output logic              web,
    output logic [ADDR_W-1:0] addrb,
    output logic [DATA_W-1:0] dib,
    output logic              in_fin,
    output logic              in_err,
    output logic              timeout_hit,
    output logic              mism
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    ch_state_e         state_r;
    mode_e             mode_r;
    logic [DATA_W-1:0] fill_r;
    logic [15:0]       lfsr_r;
    logic [ADDR_W-1:0] addr_r;
    logic [WAIT_W-1:0] wait_r;
    logic              enb_r;
    logic              web_r;
    logic [ADDR_W-1:0] addrb_r;
    logic [DATA_W-1:0] dib_r;
    logic              leave_access_s;

    // Write data for the next access; an all-ones LFSR slice is mapped to zero.
    function automatic logic [DATA_W-1:0] write_data(input mode_e m,
                                                     input logic [DATA_W-1:0] f,
                                                     input logic [15:0] l);
        logic [DATA_W-1:0] d;
        case (m)
            MODE_ZERO:  d = {DATA_W{1'b0}};
            MODE_CONST: d = f;
            MODE_PRNG: begin
                d = l[DATA_W-1:0];
                if (&d) begin
                    d = {DATA_W{1'b0}};
                end else begin
                    d = d;
                end
            end
            default:    d = {DATA_W{1'b0}};
        endcase
        return d;
    endfunction

    assign leave_access_s = abort || dob_valid || (wait_r == WAIT_LAST);

    // Channel FSM with registered RAM port outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_ZERO;
            fill_r  <= {DATA_W{1'b0}};
            lfsr_r  <= SEED;
            addr_r  <= {ADDR_W{1'b0}};
            wait_r  <= {WAIT_W{1'b0}};
            enb_r   <= 1'b0;
            web_r   <= 1'b0;
            addrb_r <= {ADDR_W{1'b0}};
            dib_r   <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        // Every pass restarts the pseudo-random sequence from the seed.
                        state_r <= ST_ACCESS;
                        mode_r  <= mode_e'(mode);
                        fill_r  <= fill_value;
                        lfsr_r  <= SEED;
                        addr_r  <= {ADDR_W{1'b0}};
                        wait_r  <= {WAIT_W{1'b0}};
                        enb_r   <= 1'b1;
                        web_r   <= (mode_e'(mode) != MODE_CHECK);
                        addrb_r <= {ADDR_W{1'b0}};
                        dib_r   <= write_data(mode_e'(mode), fill_value, SEED);
                    end
                end
                ST_ACCESS: begin
                    if (leave_access_s) begin
                        enb_r   <= 1'b0;
                        web_r   <= 1'b0;
                        addrb_r <= {ADDR_W{1'b0}};
                        dib_r   <= {DATA_W{1'b0}};
                    end
                    if (abort) begin
                        state_r <= ST_FIN;
                    end else if (dob_valid) begin
                        state_r <= ST_GAP;
                        if (mode_r == MODE_PRNG) begin
                            lfsr_r <= lfsr_step(lfsr_r);
                        end
                    end else if (wait_r == WAIT_LAST) begin
                        state_r <= ST_ERR;
                    end else begin
                        wait_r <= wait_r + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state_r <= ST_FIN;
                    end else if (addr_r < ADDR_LAST) begin
                        state_r <= ST_ACCESS;
                        addr_r  <= addr_r + 1'b1;
                        wait_r  <= {WAIT_W{1'b0}};
                        enb_r   <= 1'b1;
                        web_r   <= (mode_r != MODE_CHECK);
                        addrb_r <= addr_r + 1'b1;
                        dib_r   <= write_data(mode_r, fill_r, lfsr_r);
                    end else begin
                        state_r <= ST_FIN;
                    end
                end
                ST_ERR: begin
                    state_r <= ST_FIN;
                end
                ST_FIN: begin
                    if (fin_ack) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    enb_r   <= 1'b0;
                    web_r   <= 1'b0;
                    addrb_r <= {ADDR_W{1'b0}};
                    dib_r   <= {DATA_W{1'b0}};
                end
            endcase
        end
    end

    assign enb   = enb_r;
    assign web   = web_r;
    assign addrb = addrb_r;
    assign dib   = dib_r;

    assign in_fin      = (state_r == ST_FIN);
    assign in_err      = (state_r == ST_ERR);
    // An abort in the same cycle wins over both completion and timeout.
    assign timeout_hit = (state_r == ST_ACCESS) && !abort && !dob_valid && (wait_r == WAIT_LAST);
    assign mism        = (state_r == ST_ACCESS) && !abort && dob_valid &&
                         (mode_r == MODE_CHECK) && (dob != fill_r);

endmodule

// File: rtl/sketch_ram_init.sv
// Bucket-RAM initialiser top: fills or checks NUM_CH RAMs of depth
// BASE_DEPTH >> k in parallel, one channel FSM per RAM.
// Ports:
//   sys_clk, rst_n  clock / async active-low reset
//   start           pulse starting a pass (ignored while busy or on done)
//   mode            0 zero, 1 constant, 2 pseudo-random, 3 readback check
//   fill_value      constant for modes 1 and 3
//   busy            pass in progress
//   done            one-cycle end-of-pass pulse
//   error           sticky access timeout, cleared by the next start
//   mismatch_cnt    saturating readback mismatch count of the last pass
//   ram             RAM port bundle (master side)
module sketch_ram_init
    import sketch_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 4,
    parameter int ADDR_W     = 12,
    parameter int BASE_DEPTH = DEF_BASE_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       mismatch_cnt,
    sketch_ram_init_if.master ram
);

    logic                     busy_r;
    logic                     done_r;
    logic                     error_r;
    logic [15:0]              mismatch_cnt_r;
    logic                     accept_s;
    logic                     abort_s;
    logic                     all_fin_s;
    logic [NUM_CH-1:0]        fin_s;
    logic [NUM_CH-1:0]        err_s;
    logic [NUM_CH-1:0]        timeout_s;
    logic [NUM_CH-1:0]        mism_s;
    logic [NUM_CH-1:0]        enb_s;
    logic [NUM_CH-1:0]        web_s;
    logic [NUM_CH*ADDR_W-1:0] addrb_s;
    logic [NUM_CH*DATA_W-1:0] dib_s;
    logic [15:0]              mism_add_s;
    logic [16:0]              mism_sum_s;

    // done blocks start so a pulse coinciding with end-of-pass is dropped.
    assign accept_s  = start && !busy_r && !done_r;
    assign abort_s   = |err_s;
    assign all_fin_s = &fin_s;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        sketch_ram_init_ch #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .DEPTH   (BASE_DEPTH >> k),
            .TIMEOUT (TIMEOUT),
            .SEED    (LFSR_SEED ^ 16'(k))
        ) u_ch (
            .sys_clk     (sys_clk),
            .rst_n       (rst_n),
            .start       (accept_s),
            .abort       (abort_s),
            .fin_ack     (done_r),
            .mode        (mode),
            .fill_value  (fill_value),
            .dob         (ram.dob[k*DATA_W +: DATA_W]),
            .dob_valid   (ram.dob_valid[k]),
            .enb         (enb_s[k]),
            .web         (web_s[k]),
            .addrb       (addrb_s[k*ADDR_W +: ADDR_W]),
            .dib         (dib_s[k*DATA_W +: DATA_W]),
            .in_fin      (fin_s[k]),
            .in_err      (err_s[k]),
            .timeout_hit (timeout_s[k]),
            .mism        (mism_s[k])
        );
    end

    assign ram.enb   = enb_s;
    assign ram.web   = web_s;
    assign ram.addrb = addrb_s;
    assign ram.dib   = dib_s;

    // Number of channels reporting a mismatch this cycle, plus saturating sum.
    always_comb begin
        mism_add_s = 16'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            mism_add_s = mism_add_s + {15'd0, mism_s[k]};
        end
        mism_sum_s = {1'b0, mismatch_cnt_r} + {1'b0, mism_add_s};
    end

    // Pass control: busy/done handshake, sticky error, mismatch accumulator.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            mismatch_cnt_r <= 16'd0;
        end else begin
            // Channels stay in FIN during the done cycle, so gate on !done_r.
            done_r <= all_fin_s && !done_r;
            if (all_fin_s && !done_r) begin
                busy_r <= 1'b0;
            end else if (accept_s) begin
                busy_r <= 1'b1;
            end
            if (accept_s) begin
                error_r <= 1'b0;
            end else if (|timeout_s) begin
                error_r <= 1'b1;
            end
            if (accept_s) begin
                mismatch_cnt_r <= 16'd0;
            end else if (mism_sum_s[16]) begin
                mismatch_cnt_r <= 16'hFFFF;
            end else begin
                mismatch_cnt_r <= mism_sum_s[15:0];
            end
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign mismatch_cnt = mismatch_cnt_r;

endmodule

// File: doc/sketch_ram_init.md
SKETCH_RAM_INIT -- requirements
Module: sketch_ram_init

Interface
REQ-001 Parameter NUM_CH, default 3, number of bucket-RAM channels.
REQ-002 Parameter DATA_W, default 4, counter/bucket width.
REQ-003 Parameter ADDR_W, default 12, address width of every channel port.
REQ-004 Parameter BASE_DEPTH, default 2140, depth of channel 0; channel k depth = BASE_DEPTH >> k (2140/1070/535).
REQ-005 Parameter TIMEOUT, default 255, max cycles to wait for dob_valid per access.
REQ-006 sys_clk  in  1  single clock, all logic rising-edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle pulse, begins a pass on all channels; ignored while busy.
REQ-009 mode  in  2  0 zero-fill, 1 constant-fill, 2 pseudo-random fill, 3 readback-check; sampled with start.
REQ-010 fill_value  in  DATA_W  constant for modes 1 and 3; sampled with start.
REQ-011 busy  out  1  high from the cycle after accepted start until the pass ends.
REQ-012 done  out  1  one-cycle pulse when all channels finish.
REQ-013 error  out  1  sticky timeout flag, cleared by next accepted start.
REQ-014 mismatch_cnt  out  16  readback mismatches in the last pass, saturating at 16'hFFFF.
REQ-015 enb, web  out  NUM_CH  per-channel enable / write-enable, bit k = channel k.
REQ-016 addrb  out  NUM_CH*ADDR_W, dib  out  NUM_CH*DATA_W  flattened, channel k in slice k.
REQ-017 dob  in  NUM_CH*DATA_W, dob_valid  in  NUM_CH  per-channel read data / access-complete.

Function
REQ-018 Each channel SHALL run an independent FSM: IDLE, ACCESS, GAP, FIN, ERR; all channels start in the same cycle.
REQ-019 IDLE + accepted start -> ACCESS next cycle with enb=1, addrb=0, web=1 (modes 0-2) or web=0 (mode 3); outputs registered.
REQ-020 ACCESS holds enb/web/addrb/dib stable until dob_valid=1; then -> GAP with enb=web=0, addrb=0, dib=0 for exactly one cycle.
REQ-021 GAP -> ACCESS with addrb+1 if addrb < depth_k-1, else -> FIN.
REQ-022 dib: mode 0 = 0; mode 1 = fill_value; mode 2 = low DATA_W bits of a per-channel 16-bit Galois LFSR (taps 16,14,13,11, seed 16'hACE1 ^ k), advanced once per accepted write; all-ones result replaced by 0.
REQ-023 Mode 3: on dob_valid, dob != fill_value increments mismatch_cnt; simultaneous mismatches on several channels add their count in one cycle.
REQ-024 Wait counter cleared on entry to ACCESS; reaching TIMEOUT without dob_valid -> ERR, enb=web=0, error=1.
REQ-025 Any channel in ERR aborts the pass: all channels go to FIN next cycle with ports deasserted.
REQ-026 When all channels are in FIN: done pulses one cycle, busy falls same cycle, FSMs return to IDLE next cycle.
REQ-027 dob_valid in IDLE, GAP or FIN SHALL be ignored.
REQ-028 start coinciding with done SHALL be ignored.

Reset
REQ-029 rst_n low SHALL immediately force all FSMs to IDLE and enb, web, addrb, dib, busy, done, error, mismatch_cnt to 0, LFSRs to their seeds, including mid-pass.
REQ-030 After rst_n rises, no access SHALL start without a new start pulse.

Structure
REQ-031 Shared package sketch_pkg SHALL hold the mode encodings, FSM state encoding, LFSR taps/seed and default depth/timeout constants.
REQ-032 One sub-module sketch_ram_init_ch (one channel FSM, address/wait counters, LFSR) SHALL be instantiated NUM_CH times via generate; the top holds start capture, abort/done combining, mismatch adder.

Verification
REQ-033 Mode 0, responder dob_valid 1 cycle after enb: 2140/1070/535 writes with data 0, done pulses once, busy low after.
REQ-034 Mode 1, fill_value=4'h9, random 1-5 cycle dob_valid latency: every write has dib=9, last addrb per channel 2139/1069/534.
REQ-035 Mode 2: dib sequence per channel matches reference LFSR model, never 4'hF.
REQ-036 Mode 3 with memory model holding 9 except 7 corrupted words: mismatch_cnt=7, no writes (web=0 throughout).
REQ-037 Channel 1 withholds dob_valid at address 10: error=1 after 255 wait cycles, all enb=0, done pulses, mismatch_cnt unchanged.
REQ-038 rst_n low at channel 0 address 500, then start again: outputs 0 during reset, new pass restarts at address 0 on all channels.
